mem_wb_stage: RTL and testbench

//  Parametrised MEM->WB pipeline register, successor to the fixed 32-bit MEM/WB latch.
//  - Adds stall and flush control, a valid bit, load byte/half extension and jal link-register handling.
//  - Resolves the final writeback (target, enable, data) from same-cycle MEM inputs.
//  - Feeds the register-file write port and the EX forwarding unit, and keeps a retired-instruction count.

---
 rtl/mem_wb_stage_pkg.sv | 5 +
 rtl/mem_wb_stage_if.sv | 34 +++
 rtl/mem_wb_stage_load_extend.sv | 28 ++
 rtl/mem_wb_stage.sv | 66 ++++++
 tb/tb_mem_wb_stage.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: shared load-size encoding and link-register default for the MEM/WB slice
package mem_wb_stage_pkg;
    typedef enum logic [1:0] {LD_B = 2'd0, LD_H = 2'd1, LD_W = 2'd2} ld_size_e;
    localparam int LINK_REG_DEFAULT = 31;
endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: MEM-side inputs, stall/flush control and WB-side results of the MEM->WB register
interface mem_wb_stage_if #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int RETIRE_W = 32
);
    logic                stall;
    logic                flush;
    logic                mem_valid;
    logic [DATA_W-1:0]   mem_data;
    logic [DATA_W-1:0]   mem_alu_result;
    logic [DATA_W-1:0]   mem_pc_plus4;
    logic [REG_AW-1:0]   mem_rd;
    logic                mem_reg_write;
    logic                mem_mem_to_reg;
    logic                mem_jal;
    logic [1:0]          mem_ld_size;
    logic                mem_ld_unsigned;
    logic                wb_valid;
    logic [REG_AW-1:0]   wb_writereg;
    logic                wb_reg_write_final;
    logic [DATA_W-1:0]   wb_wdata;
    logic [RETIRE_W-1:0] retire_count;
    modport master (
        output stall, flush, mem_valid, mem_data, mem_alu_result, mem_pc_plus4, mem_rd,
               mem_reg_write, mem_mem_to_reg, mem_jal, mem_ld_size, mem_ld_unsigned,
        input  wb_valid, wb_writereg, wb_reg_write_final, wb_wdata, retire_count
    );
    modport slave (
        input  stall, flush, mem_valid, mem_data, mem_alu_result, mem_pc_plus4, mem_rd,
               mem_reg_write, mem_mem_to_reg, mem_jal, mem_ld_size, mem_ld_unsigned,
        output wb_valid, wb_writereg, wb_reg_write_final, wb_wdata, retire_count
    );
endinterface

// File: rtl/mem_wb_stage_load_extend.sv
// load_extend: selects the byte/half/word lane of an aligned load and sign- or zero-extends it
module load_extend
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        addr,
    input  logic [1:0]        size,
    input  logic              ld_unsigned,
    output logic [DATA_W-1:0] ext
);
    logic [31:0]              word;
    logic [7:0]               b;
    logic [15:0]              h;
    logic signed [DATA_W-1:0] sw;
    always_comb begin
        word = data[31:0];
        b    = word[{addr, 3'b000} +: 8];
        h    = addr[1] ? word[31:16] : word[15:0];
        sw   = $signed(word);
        // reserved size 2'b11 falls through to the word path
        ext  = size == LD_B ? {{(DATA_W-8){~ld_unsigned & b[7]}}, b}
             : size == LD_H ? {{(DATA_W-16){~ld_unsigned & h[15]}}, h}
             : ld_unsigned  ? DATA_W'(word)
             : sw;
    end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM->WB pipeline register with stall/flush, load extension, jal linking and retire count
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int LINK_REG = LINK_REG_DEFAULT,
    parameter int RETIRE_W = 32
) (
    input logic         clk,
    input logic         reset,
    mem_wb_stage_if.slave bus
);
    logic [DATA_W-1:0] ext_load;
    logic [REG_AW-1:0] target;
    logic              write_en;
    logic [DATA_W-1:0] wdata;
    logic              load;

    load_extend #(.DATA_W(DATA_W)) u_ext (
        .data       (bus.mem_data),
        .addr       (bus.mem_alu_result[1:0]),
        .size       (bus.mem_ld_size),
        .ld_unsigned(bus.mem_ld_unsigned),
        .ext        (ext_load)
    );

    always_comb begin
        target   = bus.mem_jal ? REG_AW'(LINK_REG) : bus.mem_rd;
        write_en = bus.mem_valid & (bus.mem_reg_write | bus.mem_jal) & (target != '0);
        wdata    = bus.mem_jal ? bus.mem_pc_plus4 : bus.mem_mem_to_reg ? ext_load : bus.mem_alu_result;
        load     = ~bus.flush & ~bus.stall;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.wb_valid           <= 1'b0;
            bus.wb_writereg        <= '0;
            bus.wb_reg_write_final <= 1'b0;
            bus.wb_wdata           <= '0;
        end else if (bus.flush) begin
            bus.wb_valid           <= 1'b0;
            bus.wb_writereg        <= '0;
            bus.wb_reg_write_final <= 1'b0;
            bus.wb_wdata           <= '0;
        end else if (!bus.stall) begin
            bus.wb_valid           <= bus.mem_valid;
            bus.wb_writereg        <= target;
            bus.wb_reg_write_final <= write_en;
            bus.wb_wdata           <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bus.retire_count <= '0;
        else if (load && bus.mem_valid)
            bus.retire_count <= bus.retire_count + 1'b1;
    end

`ifndef SYNTHESIS
    always @(posedge clk)
        if (bus.wb_reg_write_final)
            $display("[WB][%0t] write r%0d <= 0x%h", $time, bus.wb_writereg, bus.wb_wdata);
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: table vectors, corner sequences and random stimulus against a behavioural model
module tb_mem_wb_stage;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        stall = 0, flush = 0, valid = 0, rw = 0, m2r = 0, jal = 0, uns = 0;
    logic [63:0] data = 0, alu = 0, pc4 = 0;
    logic [4:0]  rd = 0;
    logic [1:0]  size = 0;

    mem_wb_stage_if #(.DATA_W(32), .RETIRE_W(32)) i32 ();
    mem_wb_stage_if #(.DATA_W(64), .RETIRE_W(32)) i64 ();
    mem_wb_stage_if #(.DATA_W(32), .RETIRE_W(4))  i4  ();

    assign {i32.stall, i64.stall, i4.stall}                   = {3{stall}};
    assign {i32.flush, i64.flush, i4.flush}                   = {3{flush}};
    assign {i32.mem_valid, i64.mem_valid, i4.mem_valid}       = {3{valid}};
    assign {i32.mem_reg_write, i64.mem_reg_write, i4.mem_reg_write}    = {3{rw}};
    assign {i32.mem_mem_to_reg, i64.mem_mem_to_reg, i4.mem_mem_to_reg} = {3{m2r}};
    assign {i32.mem_jal, i64.mem_jal, i4.mem_jal}             = {3{jal}};
    assign {i32.mem_ld_unsigned, i64.mem_ld_unsigned, i4.mem_ld_unsigned} = {3{uns}};
    assign {i32.mem_rd, i64.mem_rd, i4.mem_rd}                = {3{rd}};
    assign {i32.mem_ld_size, i64.mem_ld_size, i4.mem_ld_size} = {3{size}};
    assign i32.mem_data = data[31:0];
    assign i4.mem_data  = data[31:0];
    assign i64.mem_data = data;
    assign i32.mem_alu_result = alu[31:0];
    assign i4.mem_alu_result  = alu[31:0];
    assign i64.mem_alu_result = alu;
    assign i32.mem_pc_plus4 = pc4[31:0];
    assign i4.mem_pc_plus4  = pc4[31:0];
    assign i64.mem_pc_plus4 = pc4;

    mem_wb_stage #(.DATA_W(32), .RETIRE_W(32)) d32 (.clk(clk), .reset(reset), .bus(i32));
    mem_wb_stage #(.DATA_W(64), .RETIRE_W(32)) d64 (.clk(clk), .reset(reset), .bus(i64));
    mem_wb_stage #(.DATA_W(32), .RETIRE_W(4))  dw  (.clk(clk), .reset(reset), .bus(i4));

    int n_chk = 0, n_fail = 0;
    logic        ev = 0, ewe = 0;
    logic [4:0]  erd = 0;
    logic [63:0] ewd = 0, cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // value arithmetic on the selected lane, two's complement by subtraction
    function automatic logic [63:0] ext_model(input logic [63:0] d, input logic [63:0] a,
                                              input logic [1:0] sz, input logic u);
        logic [63:0] w, v;
        int bits;
        w = {32'd0, d[31:0]};
        if (sz == 2'd0) begin bits = 8;  v = (w >> (8 * a[1:0])) & 64'hFF; end
        else if (sz == 2'd1) begin bits = 16; v = (w >> (16 * a[1])) & 64'hFFFF; end
        else begin bits = 32; v = w; end
        if (!u && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
        return v;
    endfunction

    task automatic model_edge();
        logic [4:0] t;
        if (flush) begin
            ev = 0; ewe = 0; erd = 0; ewd = 0;
        end else if (!stall) begin
            t   = jal ? 5'd31 : rd;
            ev  = valid;
            erd = t;
            ewe = valid && (rw || jal) && t != 0;
            ewd = jal ? pc4 : m2r ? ext_model(data, alu, size, uns) : alu;
            if (valid) cnt = cnt + 1;
        end
    endtask

    task automatic model_reset();
        ev = 0; ewe = 0; erd = 0; ewd = 0; cnt = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid32"}, 64'(i32.wb_valid), 64'(ev));
        chk({tag, ".reg32"},   64'(i32.wb_writereg), 64'(erd));
        chk({tag, ".we32"},    64'(i32.wb_reg_write_final), 64'(ewe));
        chk({tag, ".wd32"},    64'(i32.wb_wdata), 64'(ewd[31:0]));
        chk({tag, ".cnt32"},   64'(i32.retire_count), 64'(cnt[31:0]));
        chk({tag, ".valid64"}, 64'(i64.wb_valid), 64'(ev));
        chk({tag, ".reg64"},   64'(i64.wb_writereg), 64'(erd));
        chk({tag, ".we64"},    64'(i64.wb_reg_write_final), 64'(ewe));
        chk({tag, ".wd64"},    i64.wb_wdata, ewd);
        chk({tag, ".cnt4"},    64'(i4.retire_count), 64'(cnt[3:0]));
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_op(input logic v, input logic [4:0] r, input logic w, input logic m,
                          input logic j, input logic [1:0] s, input logic u,
                          input logic [63:0] a, input logic [63:0] d, input logic [63:0] p);
        valid = v; rd = r; rw = w; m2r = m; jal = j; size = s; uns = u; alu = a; data = d; pc4 = p;
    endtask

    task automatic rand_op();
        set_op($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom),
               $urandom_range(0, 5) == 0, 2'($urandom), 1'($urandom),
               {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    endtask

    typedef struct {
        logic        v, w, m, j, u;
        logic [4:0]  r;
        logic [1:0]  s;
        logic [63:0] a, d, p;
        logic        e_valid, e_en;
        logic [4:0]  e_reg;
        logic [63:0] e_wd;
    } vec_t;

    localparam logic [63:0] LD = 64'h0000_0000_80FF_7F01;

    initial begin
        vec_t vt[$];
        vt.push_back('{1,1,0,0,0, 5, 2'd2, 64'h1234, 0, 0,             1,1, 5, 64'h1234});
        vt.push_back('{1,1,1,0,0, 7, 2'd0, 64'h3, LD, 0,               1,1, 7, 64'hFFFF_FFFF_FFFF_FF80});
        vt.push_back('{1,1,1,0,1, 7, 2'd0, 64'h3, LD, 0,               1,1, 7, 64'h80});
        vt.push_back('{1,1,1,0,0, 7, 2'd1, 64'h0, LD, 0,               1,1, 7, 64'h7F01});
        vt.push_back('{1,1,1,0,0, 7, 2'd1, 64'h2, LD, 0,               1,1, 7, 64'hFFFF_FFFF_FFFF_80FF});
        vt.push_back('{1,1,1,0,0, 7, 2'd1, 64'h3, LD, 0,               1,1, 7, 64'hFFFF_FFFF_FFFF_80FF});
        vt.push_back('{1,1,1,0,1, 7, 2'd1, 64'h2, LD, 0,               1,1, 7, 64'h80FF});
        vt.push_back('{1,1,1,0,0, 7, 2'd2, 64'h0, LD, 0,               1,1, 7, 64'hFFFF_FFFF_80FF_7F01});
        vt.push_back('{1,1,1,0,1, 7, 2'd2, 64'h0, LD, 0,               1,1, 7, 64'h0000_0000_80FF_7F01});
        vt.push_back('{1,1,1,0,0, 7, 2'd3, 64'h0, LD, 0,               1,1, 7, 64'hFFFF_FFFF_80FF_7F01});
        vt.push_back('{1,1,1,0,0, 7, 2'd0, 64'h1, LD, 0,               1,1, 7, 64'h7F});
        vt.push_back('{1,1,1,0,0, 7, 2'd0, 64'h2, LD, 0,               1,1, 7, 64'hFFFF_FFFF_FFFF_FFFF});
        vt.push_back('{1,0,0,1,0, 0, 2'd2, 64'h55, 0, 64'h0040_0010,  1,1, 31, 64'h0040_0010});
        vt.push_back('{1,1,0,0,0, 0, 2'd2, 64'h99, 0, 0,               1,0, 0, 64'h99});
        vt.push_back('{0,1,0,0,0, 9, 2'd2, 64'h77, 0, 0,               0,0, 9, 64'h77});

        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 0;

        foreach (vt[k]) begin
            set_op(vt[k].v, vt[k].r, vt[k].w, vt[k].m, vt[k].j, vt[k].s, vt[k].u, vt[k].a, vt[k].d, vt[k].p);
            tick($sformatf("vec%0d", k));
            chk($sformatf("vec%0d.tvalid", k), 64'(i64.wb_valid), 64'(vt[k].e_valid));
            chk($sformatf("vec%0d.ten", k),    64'(i32.wb_reg_write_final), 64'(vt[k].e_en));
            chk($sformatf("vec%0d.treg", k),   64'(i32.wb_writereg), 64'(vt[k].e_reg));
            chk($sformatf("vec%0d.twd64", k),  i64.wb_wdata, vt[k].e_wd);
            chk($sformatf("vec%0d.twd32", k),  64'(i32.wb_wdata), 64'(vt[k].e_wd[31:0]));
        end

        set_op(1, 12, 1, 0, 0, 2'd2, 0, 64'hABCD, 0, 0);
        tick("pre_stall");
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            rand_op();
            tick("stall");
            chk("stall.frozen", i64.wb_wdata, 64'hABCD);
        end
        flush = 1;
        set_op(1, 4, 1, 0, 0, 2'd2, 0, 64'h42, 0, 0);
        tick("flush_stall");
        chk("flush.bubble", {62'd0, i32.wb_valid, i32.wb_reg_write_final}, 64'd0);
        flush = 0; stall = 0;
        set_op(1, 3, 1, 0, 0, 2'd2, 0, 64'h31, 0, 0);
        tick("after_flush");
        chk("after_flush.wd", 64'(i32.wb_wdata), 64'h31);

        stall = 1;
        set_op(1, 8, 1, 0, 0, 2'd2, 0, 64'h5, 0, 0);
        #3 reset = 1;
        #1;
        model_reset();
        check_all("reset_mid_stall");
        @(posedge clk);
        #1 reset = 0;
        stall = 0;
        tick("post_reset");

        reset = 1;
        #1;
        model_reset();
        @(posedge clk);
        #1 reset = 0;
        for (int k = 0; k < 17; k++) begin
            set_op(1, 5'(k + 1), 1, 0, 0, 2'd2, 0, 64'(k), 0, 0);
            tick("wrap");
        end
        chk("wrap4.count", 64'(i4.retire_count), 64'd1);
        chk("wrap32.count", 64'(i32.retire_count), 64'd17);

        for (int k = 0; k < 300; k++) begin
            stall = $urandom_range(0, 4) == 0;
            flush = $urandom_range(0, 7) == 0;
            rand_op();
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
